decode_stage_ctrl: RTL and testbench
====================================

Name: decode_stage_ctrl

Overview:
Owns the IF/ID pipeline register and sequences the decode stage of the pipelined RV32I core. It captures fetched instructions, registers the immediate-format select that feeds the sign-extend unit, and schedules hazards:
- load-use stalls
- branch/jump redirect flushes
- a post-redirect drain window that discards stale fetch responses

It sits between the fetch unit (imem with a valid handshake) and the decode/execute datapath, and drives StallF, StallD and FlushE to the rest of the pipeline.

Parameters:
D_WIDTH, 32, data/instruction/PC width
DRAIN_CYCLES, 1, fetch responses discarded after a redirect (1..7)
NOP_INSTR, 32'h00000013, instruction loaded into ID on bubble/flush/reset (addi x0,x0,0)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous active-high reset
instrF  input  D_WIDTH  instruction word from imem
PCF  input  D_WIDTH  PC of instrF
PCPlus4F  input  D_WIDTH  PCF+4
fetch_validF  input  1  instrF/PCF valid this cycle
RdE  input  5  destination register of instruction in EX
LoadE  input  1  instruction in EX is a load (ResultSrcE selects memory)
PCSrcE  input  1  taken branch/jump resolved in EX (redirect)
instrD  output  D_WIDTH  registered instruction for decode
PCD  output  D_WIDTH  registered PC
PCPlus4D  output  D_WIDTH  registered PC+4
validD  output  1  instrD is a real instruction
ImmSrcD  output  2  immediate-extend select, registered with instrD
StallF  output  1  hold PC / fetch
StallD  output  1  hold IF/ID (informational copy of internal hold)
FlushE  output  1  insert bubble into ID/EX next edge

Behaviour:
- Reset (async, rst=1): instrD=NOP_INSTR, PCD=0, PCPlus4D=0, validD=0, ImmSrcD=2'b00, state=RUN, drain count=0. StallF, StallD and FlushE read 0 while rst is high.
- States: RUN, LD_STALL, DRAIN.
- Hazard decode (combinational, from the current instrD, only when validD=1):
  - rs1 used for opcodes 19, 51, 99, 3, 35, 103.
  - rs2 used for opcodes 51, 99, 35.
  - load_use = LoadE && RdE!=0 && ((rs1 used && instrD[19:15]==RdE) || (rs2 used && instrD[24:20]==RdE)).
- Priority: PCSrcE > load_use > normal.
- PCSrcE=1 (any state):
  - StallF=0, StallD=0, FlushE=1.
  - IF/ID loads NOP_INSTR with validD=0 and ImmSrcD=0.
  - Next state is DRAIN with count=DRAIN_CYCLES; with DRAIN_CYCLES=0, next state is RUN.
- RUN, load_use=1:
  - StallF=1, StallD=1, FlushE=1.
  - IF/ID holds all fields.
  - Next state LD_STALL.
- LD_STALL: exactly one stall cycle per load.
  - No hazard re-check; the bubble now in EX cannot be a load.
  - StallF=StallD=FlushE=0.
  - IF/ID loads normally; next state RUN.
- DRAIN:
  - Each cycle with fetch_validF=1, the response is discarded and count decrements.
  - IF/ID loads NOP_INSTR with validD=0.
  - When the decrement reaches 0, next state RUN.
  - fetch_validF=0 cycles do not decrement.
- Normal load (RUN or LD_STALL, no stall):
  - fetch_validF=1: instrD<=instrF, PCD<=PCF, PCPlus4D<=PCPlus4F, validD<=1.
  - fetch_validF=0: NOP_INSTR loaded, validD<=0, PCD/PCPlus4D keep old values.
- ImmSrcD register:
  - Loaded together with instrD: 2'b01 if a valid instruction with opcode in {55, 19, 99, 3, 35, 103, 111}, else 2'b00.
  - Held during a stall.
  - Latency 1 cycle from fetch, aligned with instrD.
- Simultaneous PCSrcE and load_use: PCSrcE wins; no stall is taken, the stalled instruction is flushed.
- Reset mid-stall or mid-drain returns immediately to the reset state.

Optional Feature:
STALL_PERF_EN
- Defined: adds output stall_cnt (32 bits, reset 0). It increments by 1 on every edge where StallD=1 or FlushE=1, and wraps at 2^32-1 to 0.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Test Plan:
- Reset, then fetch_validF=1 with instrF=32'h00500093 (addi x1,x0,5), PCF=0 -> next edge instrD=32'h00500093, validD=1, ImmSrcD=01, PCD=0, PCPlus4D=4.
- instrD=32'h002081B3 (add x3,x1,x2) with LoadE=1, RdE=2 -> StallF=StallD=FlushE=1 for exactly one cycle, instrD held, then 0; stall repeats only if a new load is in EX.
- Same add with LoadE=1, RdE=0 -> no stall.
- PCSrcE=1 with DRAIN_CYCLES=1 -> FlushE=1, instrD=32'h00000013, validD=0. The next valid fetch is discarded (validD stays 0). The following fetch is loaded with validD=1.
- PCSrcE=1 and load_use asserted in the same cycle -> StallF=0, FlushE=1, state DRAIN, no LD_STALL.
- fetch_validF=0 for 3 cycles in RUN -> validD=0, ImmSrcD=00, instrD=NOP_INSTR. With STALL_PERF_EN defined, stall_cnt is unchanged in these cycles and increments by 1 for the load-use scenario.

Source files
------------

// File: rtl/decode_stage_ctrl.sv
// decode_stage_ctrl
// Holds the IF/ID pipeline register of the RV32I core. It also registers the
// immediate-extend select and schedules the following decode-stage hazards:
// load-use stalls, redirect flushes, and the post-redirect drain of stale
// fetch responses.
//
// Optional build macro: STALL_PERF_EN adds a 32-bit stall_cnt output. The
// counter advances on every edge where StallD or FlushE is high.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   instrF, PCF, PCPlus4F fetch-stage instruction, PC and PC+4
//   fetch_validF          fetch payload valid this cycle
//   RdE, LoadE            destination register / load flag of the EX instruction
//   PCSrcE                taken branch/jump resolved in EX
//   instrD, PCD, PCPlus4D registered IF/ID payload
//   validD                instrD is a real instruction
//   ImmSrcD               immediate-extend select, aligned with instrD
//   StallF, StallD        hold fetch / hold IF/ID
//   FlushE                bubble into ID/EX on the next edge
//   stall_cnt             (STALL_PERF_EN only) stall/flush edge counter
module decode_stage_ctrl #(
  parameter int unsigned        D_WIDTH      = 32,
  parameter int unsigned        DRAIN_CYCLES = 1,
  parameter logic [D_WIDTH-1:0] NOP_INSTR    = D_WIDTH'(32'h00000013)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [D_WIDTH-1:0] instrF,
  input  logic [D_WIDTH-1:0] PCF,
  input  logic [D_WIDTH-1:0] PCPlus4F,
  input  logic               fetch_validF,
  input  logic [4:0]         RdE,
  input  logic               LoadE,
  input  logic               PCSrcE,
  output logic [D_WIDTH-1:0] instrD,
  output logic [D_WIDTH-1:0] PCD,
  output logic [D_WIDTH-1:0] PCPlus4D,
  output logic               validD,
  output logic [1:0]         ImmSrcD,
  output logic               StallF,
  output logic               StallD,
  output logic               FlushE
`ifdef STALL_PERF_EN
  ,
  output logic [31:0]        stall_cnt
`endif
);

  localparam int unsigned CNT_W = 3;

  localparam logic [6:0] OP_LOAD   = 7'd3;
  localparam logic [6:0] OP_IMM    = 7'd19;
  localparam logic [6:0] OP_STORE  = 7'd35;
  localparam logic [6:0] OP_REG    = 7'd51;
  localparam logic [6:0] OP_LUI    = 7'd55;
  localparam logic [6:0] OP_BRANCH = 7'd99;
  localparam logic [6:0] OP_JALR   = 7'd103;
  localparam logic [6:0] OP_JAL    = 7'd111;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LD_STALL = 2'd1,
    DRAIN    = 2'd2
  } state_t;

  // What the IF/ID register does on the next edge.
  typedef enum logic [1:0] {
    IFID_LOAD   = 2'd0,
    IFID_HOLD   = 2'd1,
    IFID_BUBBLE = 2'd2
  } ifid_op_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] drain_cnt, drain_cnt_next;
  ifid_op_t         ifid_op;
  logic             stall_f, stall_d, flush_e;

  logic [6:0] opcode_d;
  logic       rs1_used, rs2_used, load_use;
  logic [6:0] opcode_f;
  logic [1:0] imm_sel_f;

  // Hazard decode on the instruction currently sitting in ID.
  always_comb begin
    opcode_d = instrD[6:0];
    rs1_used = (opcode_d == OP_IMM)    || (opcode_d == OP_REG)   ||
               (opcode_d == OP_BRANCH) || (opcode_d == OP_LOAD)  ||
               (opcode_d == OP_STORE)  || (opcode_d == OP_JALR);
    rs2_used = (opcode_d == OP_REG) || (opcode_d == OP_BRANCH) ||
               (opcode_d == OP_STORE);
    load_use = validD && LoadE && (RdE != 5'd0) &&
               ((rs1_used && (instrD[19:15] == RdE)) ||
                (rs2_used && (instrD[24:20] == RdE)));
  end

  // Immediate select for the incoming fetch word.
  always_comb begin
    opcode_f  = instrF[6:0];
    imm_sel_f = 2'b00;
    if ((opcode_f == OP_LUI)    || (opcode_f == OP_IMM)   ||
        (opcode_f == OP_BRANCH) || (opcode_f == OP_LOAD)  ||
        (opcode_f == OP_STORE)  || (opcode_f == OP_JALR)  ||
        (opcode_f == OP_JAL)) begin
      imm_sel_f = 2'b01;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RUN;
      drain_cnt <= '0;
    end else begin
      state     <= state_next;
      drain_cnt <= drain_cnt_next;
    end
  end

  // Next-state and hazard control; a redirect overrides everything else.
  always_comb begin
    state_next     = state;
    drain_cnt_next = drain_cnt;
    ifid_op        = IFID_LOAD;
    stall_f        = 1'b0;
    stall_d        = 1'b0;
    flush_e        = 1'b0;

    if (PCSrcE) begin
      flush_e = 1'b1;
      ifid_op = IFID_BUBBLE;
      if (DRAIN_CYCLES == 0) begin
        state_next     = RUN;
        drain_cnt_next = '0;
      end else begin
        state_next     = DRAIN;
        drain_cnt_next = CNT_W'(DRAIN_CYCLES);
      end
    end else begin
      unique case (state)
        RUN: begin
          if (load_use) begin
            stall_f    = 1'b1;
            stall_d    = 1'b1;
            flush_e    = 1'b1;
            ifid_op    = IFID_HOLD;
            state_next = LD_STALL;
          end
        end
        // The bubble now in EX cannot be a load, so no re-check here.
        LD_STALL: begin
          state_next = RUN;
        end
        // Stale responses are dropped; only valid beats count down.
        DRAIN: begin
          ifid_op = IFID_BUBBLE;
          if (fetch_validF) begin
            if (drain_cnt <= CNT_W'(1)) begin
              drain_cnt_next = '0;
              state_next     = RUN;
            end else begin
              drain_cnt_next = drain_cnt - CNT_W'(1);
            end
          end
        end
        default: begin
          state_next     = RUN;
          drain_cnt_next = '0;
        end
      endcase
    end
  end

  // Hazard controls are combinational and forced low while reset is held.
  assign StallF = stall_f & ~rst;
  assign StallD = stall_d & ~rst;
  assign FlushE = flush_e & ~rst;

  // IF/ID pipeline register; PCs are kept when a NOP is inserted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instrD   <= NOP_INSTR;
      PCD      <= '0;
      PCPlus4D <= '0;
      validD   <= 1'b0;
      ImmSrcD  <= 2'b00;
    end else begin
      unique case (ifid_op)
        IFID_LOAD: begin
          if (fetch_validF) begin
            instrD   <= instrF;
            PCD      <= PCF;
            PCPlus4D <= PCPlus4F;
            validD   <= 1'b1;
            ImmSrcD  <= imm_sel_f;
          end else begin
            instrD  <= NOP_INSTR;
            validD  <= 1'b0;
            ImmSrcD <= 2'b00;
          end
        end
        IFID_BUBBLE: begin
          instrD  <= NOP_INSTR;
          validD  <= 1'b0;
          ImmSrcD <= 2'b00;
        end
        default: begin
        end
      endcase
    end
  end

`ifdef STALL_PERF_EN
  // Counts edges that stall ID or squash EX; wraps naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (StallD || FlushE) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`else
  // No stall counter in this build.
`endif

endmodule

// File: tb/tb_decode_stage_ctrl.sv
// Testbench for decode_stage_ctrl with default parameters (DRAIN_CYCLES=1).
// The main test applies a table of per-cycle vectors. Each vector lists the
// hazard outputs expected during its cycle and the IF/ID contents expected
// after the following edge. Hand-written sequences then cover reset, and
// reset asserted in the middle of a stall or a drain.
module tb_decode_stage_ctrl;

  localparam logic [31:0] NOP  = 32'h00000013;
  localparam logic [31:0] ADDI = 32'h00500093; // addi x1,x0,5
  localparam logic [31:0] ADD  = 32'h002081B3; // add x3,x1,x2
  localparam logic [31:0] LW   = 32'h00012183; // lw x3,0(x2)
  localparam logic [31:0] BEQ  = 32'h00000063; // beq x0,x0,0
  localparam logic [31:0] JAL  = 32'h0000006F; // jal x0,0
  localparam logic [31:0] LUI  = 32'h000000B7; // lui x1,0
  localparam logic [31:0] SW   = 32'h0020A023; // sw x2,0(x1)

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instrF, PCF, PCPlus4F;
  logic        fetch_validF;
  logic [4:0]  RdE;
  logic        LoadE, PCSrcE;
  logic [31:0] instrD, PCD, PCPlus4D;
  logic        validD;
  logic [1:0]  ImmSrcD;
  logic        StallF, StallD, FlushE;
`ifdef STALL_PERF_EN
  logic [31:0] stall_cnt;
  logic [31:0] exp_cnt;
`endif

  int n_vec = 0;
  int n_bad = 0;

  decode_stage_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .instrF       (instrF),
    .PCF          (PCF),
    .PCPlus4F     (PCPlus4F),
    .fetch_validF (fetch_validF),
    .RdE          (RdE),
    .LoadE        (LoadE),
    .PCSrcE       (PCSrcE),
    .instrD       (instrD),
    .PCD          (PCD),
    .PCPlus4D     (PCPlus4D),
    .validD       (validD),
    .ImmSrcD      (ImmSrcD),
    .StallF       (StallF),
    .StallD       (StallD),
    .FlushE       (FlushE)
`ifdef STALL_PERF_EN
    ,
    .stall_cnt    (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        fv;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        lde;
    logic [4:0]  rde;
    logic        pcsrc;
    logic [2:0]  stl;     // {StallF, StallD, FlushE} during the cycle
    logic [31:0] e_instr;
    logic [31:0] e_pc;    // PCD after the edge; PCPlus4D expected e_pc+4
    logic        e_v;
    logic [1:0]  e_imm;
  } vec_t;

  vec_t tbl[24];

  function automatic vec_t mk(input logic fv, input logic [31:0] instr,
                              input logic [31:0] pc, input logic lde,
                              input logic [4:0] rde, input logic pcsrc,
                              input logic [2:0] stl, input logic [31:0] e_instr,
                              input logic [31:0] e_pc, input logic e_v,
                              input logic [1:0] e_imm);
    vec_t v;
    v.fv = fv; v.instr = instr; v.pc = pc; v.lde = lde; v.rde = rde;
    v.pcsrc = pcsrc; v.stl = stl; v.e_instr = e_instr; v.e_pc = e_pc;
    v.e_v = e_v; v.e_imm = e_imm;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic fv, input logic [31:0] instr, input logic [31:0] pc,
                       input logic lde, input logic [4:0] rde, input logic pcsrc);
    fetch_validF = fv;
    instrF       = instr;
    PCF          = pc;
    PCPlus4F     = pc + 32'd4;
    LoadE        = lde;
    RdE          = rde;
    PCSrcE       = pcsrc;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    //                fv  instr  pc     lde  rde   pcs  stl     e_instr e_pc  e_v  e_imm
    tbl[0]  = mk(1'b1, ADDI, 32'd0,  1'b0, 5'd0, 1'b0, 3'b000, ADDI, 32'd0,  1'b1, 2'b01);
    tbl[1]  = mk(1'b1, ADD,  32'd4,  1'b0, 5'd0, 1'b0, 3'b000, ADD,  32'd4,  1'b1, 2'b00);
    tbl[2]  = mk(1'b1, LW,   32'd8,  1'b1, 5'd2, 1'b0, 3'b111, ADD,  32'd4,  1'b1, 2'b00);
    tbl[3]  = mk(1'b1, ADD,  32'd8,  1'b1, 5'd2, 1'b0, 3'b000, ADD,  32'd8,  1'b1, 2'b00);
    tbl[4]  = mk(1'b1, LW,   32'd12, 1'b1, 5'd0, 1'b0, 3'b000, LW,   32'd12, 1'b1, 2'b01);
    tbl[5]  = mk(1'b1, BEQ,  32'd16, 1'b1, 5'd2, 1'b0, 3'b111, LW,   32'd12, 1'b1, 2'b01);
    tbl[6]  = mk(1'b1, BEQ,  32'd16, 1'b0, 5'd0, 1'b0, 3'b000, BEQ,  32'd16, 1'b1, 2'b01);
    tbl[7]  = mk(1'b0, ADD,  32'd20, 1'b0, 5'd0, 1'b0, 3'b000, NOP,  32'd16, 1'b0, 2'b00);
    tbl[8]  = mk(1'b0, ADD,  32'd20, 1'b0, 5'd0, 1'b0, 3'b000, NOP,  32'd16, 1'b0, 2'b00);
    tbl[9]  = mk(1'b0, ADD,  32'd20, 1'b0, 5'd0, 1'b0, 3'b000, NOP,  32'd16, 1'b0, 2'b00);
    tbl[10] = mk(1'b1, ADD,  32'd20, 1'b0, 5'd0, 1'b0, 3'b000, ADD,  32'd20, 1'b1, 2'b00);
    tbl[11] = mk(1'b1, ADDI, 32'd24, 1'b1, 5'd2, 1'b1, 3'b001, NOP,  32'd20, 1'b0, 2'b00);
    tbl[12] = mk(1'b0, ADDI, 32'd28, 1'b0, 5'd0, 1'b0, 3'b000, NOP,  32'd20, 1'b0, 2'b00);
    tbl[13] = mk(1'b1, ADDI, 32'd28, 1'b0, 5'd0, 1'b0, 3'b000, NOP,  32'd20, 1'b0, 2'b00);
    tbl[14] = mk(1'b1, ADDI, 32'd32, 1'b0, 5'd0, 1'b0, 3'b000, ADDI, 32'd32, 1'b1, 2'b01);
    tbl[15] = mk(1'b1, JAL,  32'd36, 1'b0, 5'd0, 1'b1, 3'b001, NOP,  32'd32, 1'b0, 2'b00);
    tbl[16] = mk(1'b1, ADDI, 32'd40, 1'b0, 5'd0, 1'b0, 3'b000, NOP,  32'd32, 1'b0, 2'b00);
    tbl[17] = mk(1'b1, JAL,  32'd44, 1'b0, 5'd0, 1'b0, 3'b000, JAL,  32'd44, 1'b1, 2'b01);
    tbl[18] = mk(1'b1, LUI,  32'd48, 1'b1, 5'd1, 1'b0, 3'b000, LUI,  32'd48, 1'b1, 2'b01);
    tbl[19] = mk(1'b1, SW,   32'd52, 1'b1, 5'd1, 1'b0, 3'b000, SW,   32'd52, 1'b1, 2'b01);
    tbl[20] = mk(1'b1, ADDI, 32'd56, 1'b1, 5'd2, 1'b0, 3'b111, SW,   32'd52, 1'b1, 2'b01);
    tbl[21] = mk(1'b1, ADDI, 32'd56, 1'b0, 5'd0, 1'b1, 3'b001, NOP,  32'd52, 1'b0, 2'b00);
    tbl[22] = mk(1'b1, ADDI, 32'd60, 1'b0, 5'd0, 1'b0, 3'b000, NOP,  32'd52, 1'b0, 2'b00);
    tbl[23] = mk(1'b1, ADDI, 32'd64, 1'b0, 5'd0, 1'b0, 3'b000, ADDI, 32'd64, 1'b1, 2'b01);

    // Reset with hazard inputs active: controls must still read 0.
    rst = 1'b1;
    drive(1'b1, ADD, 32'd0, 1'b1, 5'd2, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    chk("rst StallF", 32'(StallF), 32'd0);
    chk("rst StallD", 32'(StallD), 32'd0);
    chk("rst FlushE", 32'(FlushE), 32'd0);
    chk("rst instrD", instrD, NOP);
    chk("rst PCD", PCD, 32'd0);
    chk("rst PCPlus4D", PCPlus4D, 32'd0);
    chk("rst validD", 32'(validD), 32'd0);
    chk("rst ImmSrcD", 32'(ImmSrcD), 32'd0);
`ifdef STALL_PERF_EN
    exp_cnt = 32'd0;
    chk("rst stall_cnt", stall_cnt, exp_cnt);
`endif
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, NOP, 32'd0, 1'b0, 5'd0, 1'b0);

    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      drive(tbl[i].fv, tbl[i].instr, tbl[i].pc, tbl[i].lde, tbl[i].rde, tbl[i].pcsrc);
      #1;
      chk($sformatf("v%0d StallF", i), 32'(StallF), 32'(tbl[i].stl[2]));
      chk($sformatf("v%0d StallD", i), 32'(StallD), 32'(tbl[i].stl[1]));
      chk($sformatf("v%0d FlushE", i), 32'(FlushE), 32'(tbl[i].stl[0]));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d instrD", i), instrD, tbl[i].e_instr);
      chk($sformatf("v%0d PCD", i), PCD, tbl[i].e_pc);
      chk($sformatf("v%0d PCPlus4D", i), PCPlus4D, tbl[i].e_pc + 32'd4);
      chk($sformatf("v%0d validD", i), 32'(validD), 32'(tbl[i].e_v));
      chk($sformatf("v%0d ImmSrcD", i), 32'(ImmSrcD), 32'(tbl[i].e_imm));
`ifdef STALL_PERF_EN
      if (tbl[i].stl[1] || tbl[i].stl[0]) exp_cnt = exp_cnt + 32'd1;
      chk($sformatf("v%0d stall_cnt", i), stall_cnt, exp_cnt);
`endif
    end

    // Reset asserted mid-cycle while a load-use stall is being requested.
    @(negedge clk);
    drive(1'b1, ADD, 32'd100, 1'b0, 5'd0, 1'b0);
    @(negedge clk);
    drive(1'b1, ADDI, 32'd104, 1'b1, 5'd2, 1'b0);
    #1;
    chk("pre-rst StallF", 32'(StallF), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid-stall rst StallF", 32'(StallF), 32'd0);
    chk("mid-stall rst FlushE", 32'(FlushE), 32'd0);
    chk("mid-stall rst instrD", instrD, NOP);
    chk("mid-stall rst validD", 32'(validD), 32'd0);
    chk("mid-stall rst PCD", PCD, 32'd0);
`ifdef STALL_PERF_EN
    chk("mid-stall rst stall_cnt", stall_cnt, 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, ADDI, 32'd200, 1'b0, 5'd0, 1'b0);
    @(posedge clk);
    #1;
    chk("post-rst load instrD", instrD, ADDI);
    chk("post-rst load PCD", PCD, 32'd200);
    chk("post-rst load validD", 32'(validD), 32'd1);

    // Reset during a drain window: the next fetch must load, not be dropped.
    @(negedge clk);
    drive(1'b1, ADD, 32'd204, 1'b0, 5'd0, 1'b1);
    @(negedge clk);
    drive(1'b0, ADD, 32'd208, 1'b0, 5'd0, 1'b0);
    rst = 1'b1;
    #1;
    chk("mid-drain rst validD", 32'(validD), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, ADDI, 32'd300, 1'b0, 5'd0, 1'b0);
    @(posedge clk);
    #1;
    chk("post-drain-rst instrD", instrD, ADDI);
    chk("post-drain-rst PCD", PCD, 32'd300);
    chk("post-drain-rst validD", 32'(validD), 32'd1);
    chk("post-drain-rst ImmSrcD", 32'(ImmSrcD), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
